// File: rtl/sub_wide_seq.sv
// Multi-cycle wide unsigned subtractor: D = A - B - B_in, computed one
// 16-bit slice per cycle with the inter-slice borrow held in a register.
//
// state | meaning
// IDLE  | waiting for an operand bundle, in_ready high
// CALC  | subtracting slice `cnt` each cycle, NSLICE cycles total
// DONE  | result presented, out_valid high until out_ready
module sub_wide_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:1]   A,
  input  logic [WIDTH:1]   B,
  input  logic             B_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:1]   D,
  output logic             B_out,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 16;
  // Keep the counter at least one bit wide so WIDTH=16 still elaborates.
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [WIDTH:1]  a_q;
  logic [WIDTH:1]  b_q;
  logic            borrow_q;
  logic [CW-1:0]   cnt_q;
  logic [15:0]     a_sl;
  logic [15:0]     b_sl;
  logic [16:0]     diff_full;
  logic            last;
  logic            accept;

  // Status flags come straight from the state register, no input paths.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == DONE);
  assign accept    = in_valid && (state_q == IDLE);
  assign last      = (cnt_q == LAST);

  // Select the active 16-bit slice of both operands.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt_q == k[CW-1:0]) begin
        a_sl = a_q[16*k+1 +: 16];
        b_sl = b_q[16*k+1 +: 16];
      end
    end
  end

  // One ripple-borrow slice; bit 16 of the 17-bit difference is the borrow out.
  assign diff_full = {1'b0, a_sl} - {1'b0, b_sl} - {16'd0, borrow_q};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and per-slice datapath update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      D        <= '0;
      B_out    <= 1'b0;
    end else if (accept) begin
      a_q      <= A;
      b_q      <= B;
      borrow_q <= B_in;
      cnt_q    <= '0;
      D        <= '0;
    end else if (state_q == CALC) begin
      for (int k = 0; k < NSLICE; k++) begin
        if (cnt_q == k[CW-1:0]) D[16*k+1 +: 16] <= diff_full[15:0];
      end
      borrow_q <= diff_full[16];
      cnt_q    <= cnt_q + CW'(1);
      if (last) B_out <= diff_full[16];
    end
  end

endmodule

// File: tb/tb_sub_wide_seq.sv
// Bench for sub_wide_seq: directed corner cases plus random operands for a
// 64-bit instance and a 16-bit instance, checked against plain arithmetic.
module tb_sub_wide_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        iv, ir, ov, ordy, bi, bo, bsy;
  logic [64:1] a, b, d;
  logic        iv16, ir16, ov16, ordy16, bi16, bo16, bsy16;
  logic [16:1] a16, b16, d16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sub_wide_seq #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .A(a), .B(b),
    .B_in(bi), .out_valid(ov), .out_ready(ordy), .D(d), .B_out(bo), .busy(bsy)
  );

  sub_wide_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
    .B_in(bi16), .out_valid(ov16), .out_ready(ordy16), .D(d16), .B_out(bo16),
    .busy(bsy16)
  );

  // Reference: unsigned subtraction with one extra bit; the top bit is the borrow.
  function automatic logic [64:0] ref_sub(input logic [63:0] x, input logic [63:0] y,
                                           input logic bin);
    return {1'b0, x} - {1'b0, y} - {64'd0, bin};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Run one 64-bit operation from an IDLE cycle (called #1 after a posedge).
  // hold = number of cycles out_ready stays low once the result appears.
  task automatic op64(input string tag, input logic [63:0] x, input logic [63:0] y,
                      input logic bin, input int hold);
    logic [64:0] e;
    logic [63:0] d_seen;
    logic        b_seen;
    int          n;
    e = ref_sub(x, y, bin);
    iv = 1'b1; a = x; b = y; bi = bin;
    @(posedge clk); #1;
    iv = 1'b0; a = rnd64(); b = rnd64(); bi = ~bin;
    n = 0;
    while (!ov && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd4);
    chk({tag, "_D"}, d, e[63:0]);
    chk({tag, "_Bout"}, 64'(bo), 64'(e[64]));
    d_seen = d; b_seen = bo;
    for (int i = 0; i < hold; i++) begin
      iv = (i == 3); a = rnd64(); b = rnd64();
      @(posedge clk); #1;
      chk({tag, "_hold_ov"}, 64'(ov), 64'd1);
      chk({tag, "_hold_ir"}, 64'(ir), 64'd0);
      chk({tag, "_hold_D"}, d, d_seen);
      chk({tag, "_hold_Bout"}, 64'(bo), 64'(b_seen));
    end
    iv = 1'b0;
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    chk({tag, "_idle_ir"}, 64'(ir), 64'd1);
  endtask

  task automatic op16(input string tag, input logic [15:0] x, input logic [15:0] y,
                      input logic bin);
    logic [16:0] e;
    int          n;
    e = {1'b0, x} - {1'b0, y} - {16'd0, bin};
    iv16 = 1'b1; a16 = x; b16 = y; bi16 = bin;
    @(posedge clk); #1;
    iv16 = 1'b0; a16 = 16'($urandom()); b16 = 16'($urandom());
    n = 0;
    while (!ov16 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd1);
    chk({tag, "_D"}, 64'(d16), 64'(e[15:0]));
    chk({tag, "_Bout"}, 64'(bo16), 64'(e[16]));
    ordy16 = 1'b1;
    @(posedge clk); #1;
    ordy16 = 1'b0;
    chk({tag, "_idle_ir"}, 64'(ir16), 64'd1);
  endtask

  initial begin
    logic [63:0] x, y;
    int          n;
    iv = 0; ordy = 0; bi = 0; a = '0; b = '0;
    iv16 = 0; ordy16 = 0; bi16 = 0; a16 = '0; b16 = '0;

    // Reset values.
    #12;
    chk("rst_ir", 64'(ir), 64'd1);
    chk("rst_ov", 64'(ov), 64'd0);
    chk("rst_busy", 64'(bsy), 64'd0);
    chk("rst_D", d, 64'd0);
    chk("rst_Bout", 64'(bo), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corners.
    op64("xslice", 64'h0000_0000_0001_0000, 64'h1, 1'b0, 0);
    op64("wrap", 64'h0, 64'h1, 1'b0, 0);
    op64("eq_b1", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 0);
    op64("eq_b0", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 0);

    // Backpressure with an ignored request during DONE.
    op64("bp", 64'hDEAD_BEEF_0000_0001, 64'h0000_0001_FFFF_FFFF, 1'b1, 10);

    // Release with in_valid already high: no accept in DONE, accept in IDLE.
    iv = 1'b1; a = 64'h5; b = 64'h7; bi = 1'b0;
    n = 0;
    while (!ov && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("dn_lat", 64'(n), 64'd5);
    ordy = 1'b1; iv = 1'b1; a = 64'h9; b = 64'h3; bi = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    chk("dn_noacc_ir", 64'(ir), 64'd1);
    op64("after_done", 64'h9, 64'h3, 1'b1, 0);

    // Reset during the second CALC cycle.
    iv = 1'b1; a = 64'hFFFF_0000_0000_0000; b = 64'h1; bi = 1'b0;
    @(posedge clk); #1;
    iv = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", 64'(ov), 64'd0);
    chk("mid_rst_D", d, 64'd0);
    chk("mid_rst_Bout", 64'(bo), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ir", 64'(ir), 64'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ov) n++;
    end
    chk("mid_rst_no_result", 64'(n), 64'd0);

    // Random operands, including borrow-heavy and equal cases.
    for (int i = 0; i < 30; i++) begin
      x = rnd64();
      case ($urandom_range(0, 3))
        0: y = x;
        1: y = ~x;
        default: y = rnd64();
      endcase
      op64("rnd", x, y, 1'($urandom()), int'($urandom_range(0, 3)));
    end

    // 16-bit instance.
    op16("w16", 16'h8000, 16'h8001, 1'b0);
    for (int i = 0; i < 10; i++)
      op16("w16_rnd", 16'($urandom()), 16'($urandom()), 1'($urandom()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
